l80_io_fifo_bridge: RTL and testbench

CPU-side IO-space bridge between the light8080 bus and a byte-stream peripheral (UART class) running in the CPU clock domain.
- Replaces the single-entry receive flag and unbuffered transmit strobe with parametrised RX and TX FIFOs.
- Adds a status/count/control register set and a level interrupt request.
- Sits between the CPU IO decode and the flag/bus clock-domain crossings that feed the UART.

---
 rtl/l80_io_fifo_bridge.sv | 201 ++++++++++++++++++++
 tb/tb_l80_io_fifo_bridge.sv | 457 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/l80_io_fifo_bridge.sv
// IO-space bridge between the light8080 bus and a byte-stream peripheral:
// RX/TX FIFOs, status/count/control registers and a level interrupt.
module l80_io_fifo_bridge #(
  parameter logic [7:0]  BASE_ADDR = 8'h80,
  parameter int unsigned RX_AW     = 4,
  parameter int unsigned TX_AW     = 4
) (
  input  logic       clock,
  input  logic       reset2,
  input  logic       cpu_io,
  input  logic       cpu_rd,
  input  logic       cpu_wr,
  input  logic [7:0] cpu_addr,
  input  logic [7:0] cpu_dout,
  output logic [7:0] io_dout,
  input  logic       rx_valid,
  input  logic [7:0] rx_data,
  output logic       tx_valid,
  output logic [7:0] tx_data,
  input  logic       tx_busy,
  output logic       irq
);
  localparam int unsigned    RX_DEPTH    = 1 << RX_AW;
  localparam int unsigned    TX_DEPTH    = 1 << TX_AW;
  localparam logic [RX_AW:0] RX_FULL_CNT = {1'b1, {RX_AW{1'b0}}};
  localparam logic [TX_AW:0] TX_FULL_CNT = {1'b1, {TX_AW{1'b0}}};

  typedef enum logic [1:0] {TX_IDLE, TX_SEND, TX_HOLD} tx_state_t;

  // Valid/ready: rx_valid is a one-cycle push with no back-pressure; tx_valid is a
  // one-cycle request issued only when tx_busy was low in the cycle before it.

  logic [7:0]       off;
  logic             addr_hit, rd_stb, wr_stb, rd_first, wr_first;
  logic             sel_data, sel_stat, sel_ctrl;
  logic             rd_stb_q, wr_stb_q;
  logic [7:0]       rx_mem [RX_DEPTH];
  logic [7:0]       tx_mem [TX_DEPTH];
  logic [RX_AW-1:0] rx_wptr_q, rx_wptr_d, rx_rptr_q, rx_rptr_d;
  logic [RX_AW:0]   rx_cnt_q, rx_cnt_d;
  logic [TX_AW-1:0] tx_wptr_q, tx_wptr_d, tx_rptr_q, tx_rptr_d;
  logic [TX_AW:0]   tx_cnt_q, tx_cnt_d;
  logic             rx_ovr_q, rx_ovr_d;
  logic [2:0]       ctrl_q, ctrl_d;
  logic [7:0]       io_dout_q, io_dout_d;
  logic             irq_q, irq_d;
  logic             rx_full, rx_empty, tx_full, tx_empty;
  logic             rx_pop, rx_push, rx_drop, rx_flush, tx_push, tx_pop, tx_flush;
  logic [7:0]       stat, reg_rdata;
  tx_state_t        tx_state_q;
  logic             tx_valid_q;
  logic [7:0]       tx_data_q;
  logic             unused_ok;

  assign unused_ok = &{1'b0, cpu_dout[5:3]};

  assign off      = cpu_addr - BASE_ADDR;
  assign addr_hit = off < 8'd5;
  assign rd_stb   = cpu_io & cpu_rd & addr_hit;
  assign wr_stb   = cpu_io & cpu_wr & addr_hit;
  // Side effects fire only on the first cycle of a (possibly stretched) strobe.
  assign rd_first = rd_stb & ~rd_stb_q;
  assign wr_first = wr_stb & ~wr_stb_q;
  assign sel_data = off[2:0] == 3'd0;
  assign sel_stat = off[2:0] == 3'd1;
  assign sel_ctrl = off[2:0] == 3'd3;

  assign rx_full  = rx_cnt_q == RX_FULL_CNT;
  assign rx_empty = rx_cnt_q == '0;
  assign tx_full  = tx_cnt_q == TX_FULL_CNT;
  assign tx_empty = tx_cnt_q == '0;

  assign rx_pop   = rd_first & sel_data & ~rx_empty;
  assign rx_push  = rx_valid & (~rx_full | rx_pop);
  assign rx_drop  = rx_valid & rx_full & ~rx_pop;
  assign rx_flush = wr_first & sel_ctrl & cpu_dout[6];
  assign tx_push  = wr_first & sel_data & ~tx_full;
  assign tx_pop   = (tx_state_q == TX_SEND) & ~tx_empty;
  assign tx_flush = wr_first & sel_ctrl & cpu_dout[7];

  assign stat = {2'b00, rx_full, ~rx_empty, 1'b0, rx_ovr_q, tx_empty, tx_full};

  always_comb begin
    reg_rdata = 8'h00;
    if (addr_hit) begin
      case (off[2:0])
        3'd0:    reg_rdata = rx_mem[rx_rptr_q];
        3'd1:    reg_rdata = stat;
        3'd2:    reg_rdata = 8'(rx_cnt_q);
        3'd3:    reg_rdata = {5'b00000, ctrl_q};
        3'd4:    reg_rdata = 8'(tx_cnt_q);
        default: reg_rdata = 8'h00;
      endcase
    end
  end

  always_comb begin
    rx_wptr_d = rx_wptr_q;
    rx_rptr_d = rx_rptr_q;
    rx_cnt_d  = rx_cnt_q;
    rx_ovr_d  = rx_ovr_q;
    tx_wptr_d = tx_wptr_q;
    tx_rptr_d = tx_rptr_q;
    tx_cnt_d  = tx_cnt_q;
    ctrl_d    = ctrl_q;
    if (rx_flush) begin
      rx_wptr_d = '0;
      rx_rptr_d = '0;
      rx_cnt_d  = '0;
      rx_ovr_d  = 1'b0;
    end else begin
      if (rx_push) rx_wptr_d = rx_wptr_q + 1'b1;
      if (rx_pop)  rx_rptr_d = rx_rptr_q + 1'b1;
      rx_cnt_d = rx_cnt_q + {{RX_AW{1'b0}}, rx_push} - {{RX_AW{1'b0}}, rx_pop};
      // A new overrun outranks a same-cycle STAT read so the event is not lost.
      if (rx_drop)                          rx_ovr_d = 1'b1;
      else if (rd_first && sel_stat)        rx_ovr_d = 1'b0;
    end
    if (tx_flush) begin
      tx_wptr_d = '0;
      tx_rptr_d = '0;
      tx_cnt_d  = '0;
    end else begin
      if (tx_push) tx_wptr_d = tx_wptr_q + 1'b1;
      if (tx_pop)  tx_rptr_d = tx_rptr_q + 1'b1;
      tx_cnt_d = tx_cnt_q + {{TX_AW{1'b0}}, tx_push} - {{TX_AW{1'b0}}, tx_pop};
    end
    if (wr_first && sel_ctrl) ctrl_d = cpu_dout[2:0];
    io_dout_d = cpu_io ? reg_rdata : io_dout_q;
    irq_d = (ctrl_q[0] & ~rx_empty) | (ctrl_q[1] & tx_empty) | (ctrl_q[2] & rx_ovr_q);
  end

  always_ff @(posedge clock or posedge reset2) begin
    if (reset2) begin
      rd_stb_q  <= 1'b0;
      wr_stb_q  <= 1'b0;
      rx_wptr_q <= '0;
      rx_rptr_q <= '0;
      rx_cnt_q  <= '0;
      rx_ovr_q  <= 1'b0;
      tx_wptr_q <= '0;
      tx_rptr_q <= '0;
      tx_cnt_q  <= '0;
      ctrl_q    <= 3'b000;
      io_dout_q <= 8'h00;
      irq_q     <= 1'b0;
    end else begin
      rd_stb_q  <= rd_stb;
      wr_stb_q  <= wr_stb;
      rx_wptr_q <= rx_wptr_d;
      rx_rptr_q <= rx_rptr_d;
      rx_cnt_q  <= rx_cnt_d;
      rx_ovr_q  <= rx_ovr_d;
      tx_wptr_q <= tx_wptr_d;
      tx_rptr_q <= tx_rptr_d;
      tx_cnt_q  <= tx_cnt_d;
      ctrl_q    <= ctrl_d;
      io_dout_q <= io_dout_d;
      irq_q     <= irq_d;
    end
  end

  // Storage is not reset: contents become unreachable once pointers clear.
  always_ff @(posedge clock) begin
    if (rx_push && !rx_flush) rx_mem[rx_wptr_q] <= rx_data;
    if (tx_push && !tx_flush) tx_mem[tx_wptr_q] <= cpu_dout;
  end

  // HOLD spends one cycle ignoring tx_busy while the crossing raises it.
  always_ff @(posedge clock or posedge reset2) begin
    if (reset2) begin
      tx_state_q <= TX_IDLE;
      tx_valid_q <= 1'b0;
      tx_data_q  <= 8'h00;
    end else begin
      case (tx_state_q)
        TX_IDLE: begin
          tx_valid_q <= 1'b0;
          if (!tx_empty && !tx_busy) begin
            tx_state_q <= TX_SEND;
            tx_valid_q <= 1'b1;
            tx_data_q  <= tx_mem[tx_rptr_q];
          end
        end
        TX_SEND: begin
          tx_valid_q <= 1'b0;
          tx_state_q <= TX_HOLD;
        end
        default: begin
          tx_valid_q <= 1'b0;
          tx_state_q <= TX_IDLE;
        end
      endcase
    end
  end

  assign io_dout  = io_dout_q;
  assign tx_valid = tx_valid_q;
  assign tx_data  = tx_data_q;
  assign irq      = irq_q;
endmodule

// File: tb/tb_l80_io_fifo_bridge.sv
// Bench for l80_io_fifo_bridge: scenario tasks checked against a queue-based
// model of the register set and both FIFOs (depth 4 each).
module tb_l80_io_fifo_bridge;
  localparam logic [7:0] A_DATA = 8'h80, A_STAT = 8'h81, A_RXCNT = 8'h82;
  localparam logic [7:0] A_CTRL = 8'h83, A_TXCNT = 8'h84;
  localparam int RX_DEPTH = 4, TX_DEPTH = 4;

  logic       clock = 1'b0, reset2 = 1'b1;
  logic       cpu_io = 1'b0, cpu_rd = 1'b0, cpu_wr = 1'b0;
  logic [7:0] cpu_addr = 8'h00, cpu_dout = 8'h00;
  logic [7:0] io_dout;
  logic       rx_valid = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       tx_valid, tx_busy = 1'b0, irq;
  logic [7:0] tx_data;

  l80_io_fifo_bridge #(.BASE_ADDR(8'h80), .RX_AW(2), .TX_AW(2)) dut (
    .clock(clock), .reset2(reset2), .cpu_io(cpu_io), .cpu_rd(cpu_rd), .cpu_wr(cpu_wr),
    .cpu_addr(cpu_addr), .cpu_dout(cpu_dout), .io_dout(io_dout), .rx_valid(rx_valid),
    .rx_data(rx_data), .tx_valid(tx_valid), .tx_data(tx_data), .tx_busy(tx_busy), .irq(irq)
  );

  // clock / reset block
  always #5 clock = ~clock;
  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // reference model state and scoreboard
  logic [7:0] rx_q[$];
  logic       rx_ovr = 1'b0;
  logic [7:0] exp_q[$];
  logic [7:0] obs_q[$];
  int         obs_cyc[$];
  int         pass_cnt = 0, total_cnt = 0;

  always @(negedge clock) begin
    if (tx_valid === 1'b1) begin
      obs_q.push_back(tx_data);
      obs_cyc.push_back(cyc);
    end
  end

  function automatic logic [7:0] exp_stat(input int txn);
    return {2'b00, rx_q.size() == RX_DEPTH, rx_q.size() != 0, 1'b0, rx_ovr,
            txn == 0, txn == TX_DEPTH};
  endfunction

  function automatic void model_rx_push(input logic [7:0] b);
    if (rx_q.size() < RX_DEPTH) rx_q.push_back(b);
    else rx_ovr = 1'b1;
  endfunction

  // driver tasks
  task automatic cpu_read_n(input logic [7:0] addr, input int n, output logic [7:0] data);
    @(negedge clock);
    cpu_io = 1'b1; cpu_rd = 1'b1; cpu_addr = addr;
    repeat (n) @(negedge clock);
    data = io_dout;
    cpu_io = 1'b0; cpu_rd = 1'b0;
  endtask

  task automatic cpu_read(input logic [7:0] addr, output logic [7:0] data);
    cpu_read_n(addr, 1, data);
  endtask

  task automatic cpu_write(input logic [7:0] addr, input logic [7:0] d);
    @(negedge clock);
    cpu_io = 1'b1; cpu_wr = 1'b1; cpu_addr = addr; cpu_dout = d;
    @(negedge clock);
    cpu_io = 1'b0; cpu_wr = 1'b0;
  endtask

  task automatic rx_pulse(input logic [7:0] b);
    @(negedge clock);
    rx_valid = 1'b1; rx_data = b;
    @(negedge clock);
    rx_valid = 1'b0;
  endtask

  task automatic read_and_push(input logic [7:0] b, output logic [7:0] d);
    @(negedge clock);
    cpu_io = 1'b1; cpu_rd = 1'b1; cpu_addr = A_DATA; rx_valid = 1'b1; rx_data = b;
    @(negedge clock);
    d = io_dout;
    cpu_io = 1'b0; cpu_rd = 1'b0; rx_valid = 1'b0;
  endtask

  task automatic wait_obs(input int n, input int budget);
    for (int i = 0; i < budget && obs_q.size() < n; i++) @(negedge clock);
  endtask

  task automatic test_reset();
    logic [7:0] d;
    reset2 = 1'b1;
    repeat (3) @(negedge clock);
    total_cnt++;
    if ({io_dout, tx_data} !== 16'h0000) $display("FAIL reset_data io_dout=%02h tx_data=%02h exp=00", io_dout, tx_data);
    else pass_cnt++;
    total_cnt++;
    if ({tx_valid, irq} !== 2'b00) $display("FAIL reset_ctl tx_valid=%b irq=%b exp=0", tx_valid, irq);
    else pass_cnt++;
    reset2 = 1'b0;
    cpu_read(A_STAT, d);
    total_cnt++;
    if (d !== 8'h02) $display("FAIL reset_stat got=%02h exp=02", d); else pass_cnt++;
    cpu_read(A_RXCNT, d);
    total_cnt++;
    if (d !== 8'h00) $display("FAIL reset_rxcnt got=%02h exp=00", d); else pass_cnt++;
    cpu_read(A_TXCNT, d);
    total_cnt++;
    if (d !== 8'h00) $display("FAIL reset_txcnt got=%02h exp=00", d); else pass_cnt++;
    cpu_read(A_CTRL, d);
    total_cnt++;
    if (d !== 8'h00) $display("FAIL reset_ctrl got=%02h exp=00", d); else pass_cnt++;
    repeat (5) @(negedge clock);
    total_cnt++;
    if (obs_q.size() != 0 || irq !== 1'b0) $display("FAIL reset_quiet tx_pulses=%0d irq=%b exp=0/0", obs_q.size(), irq);
    else pass_cnt++;
  endtask

  task automatic test_rx_order();
    logic [7:0] d, e;
    rx_pulse(8'hA5); model_rx_push(8'hA5);
    rx_pulse(8'h3C); model_rx_push(8'h3C);
    cpu_read(A_RXCNT, d);
    total_cnt++;
    if (d !== 8'(rx_q.size())) $display("FAIL rx_cnt2 got=%02h exp=%02h", d, 8'(rx_q.size())); else pass_cnt++;
    for (int i = 0; i < 2; i++) begin
      cpu_read(A_DATA, d);
      e = rx_q.pop_front();
      total_cnt++;
      if (d !== e) $display("FAIL rx_data%0d got=%02h exp=%02h", i, d, e); else pass_cnt++;
    end
    cpu_read(A_STAT, d);
    total_cnt++;
    if (d !== exp_stat(0)) $display("FAIL rx_stat_empty got=%02h exp=%02h", d, exp_stat(0)); else pass_cnt++;
    for (int i = 0; i < 3; i++) begin
      e = 8'($urandom);
      rx_pulse(e); model_rx_push(e);
    end
    // a stretched read pops once; io_dout then shows the new head
    cpu_read_n(A_DATA, 3, d);
    void'(rx_q.pop_front());
    total_cnt++;
    if (d !== rx_q[0]) $display("FAIL rx_long_read got=%02h exp=%02h", d, rx_q[0]); else pass_cnt++;
    cpu_read(A_RXCNT, d);
    total_cnt++;
    if (d !== 8'(rx_q.size())) $display("FAIL rx_long_cnt got=%02h exp=%02h", d, 8'(rx_q.size())); else pass_cnt++;
    while (rx_q.size() != 0) begin
      cpu_read(A_DATA, d);
      e = rx_q.pop_front();
      total_cnt++;
      if (d !== e) $display("FAIL rx_drain got=%02h exp=%02h", d, e); else pass_cnt++;
    end
  endtask

  task automatic test_overrun();
    logic [7:0] d, e;
    for (int i = 0; i < 5; i++) begin
      e = 8'($urandom);
      rx_pulse(e); model_rx_push(e);
    end
    cpu_read(A_RXCNT, d);
    total_cnt++;
    if (d !== 8'd4) $display("FAIL ovr_cnt got=%02h exp=04", d); else pass_cnt++;
    cpu_read(A_STAT, d);
    total_cnt++;
    if (d !== exp_stat(0) || d !== 8'h36) $display("FAIL ovr_stat got=%02h exp=%02h", d, exp_stat(0)); else pass_cnt++;
    rx_ovr = 1'b0;
    cpu_read(A_STAT, d);
    total_cnt++;
    if (d !== exp_stat(0) || d !== 8'h32) $display("FAIL ovr_clear got=%02h exp=%02h", d, exp_stat(0)); else pass_cnt++;
    while (rx_q.size() != 0) begin
      cpu_read(A_DATA, d);
      e = rx_q.pop_front();
      total_cnt++;
      if (d !== e) $display("FAIL ovr_drain got=%02h exp=%02h", d, e); else pass_cnt++;
    end
  endtask

  task automatic test_same_cycle();
    logic [7:0] d, e, b;
    for (int i = 0; i < 4; i++) begin
      e = 8'($urandom);
      rx_pulse(e); model_rx_push(e);
    end
    b = 8'($urandom);
    read_and_push(b, d);
    e = rx_q.pop_front();
    rx_q.push_back(b);
    total_cnt++;
    if (d !== e) $display("FAIL full_pp_data got=%02h exp=%02h", d, e); else pass_cnt++;
    cpu_read(A_STAT, d);
    total_cnt++;
    if (d !== exp_stat(0)) $display("FAIL full_pp_stat got=%02h exp=%02h", d, exp_stat(0)); else pass_cnt++;
    while (rx_q.size() != 0) begin
      cpu_read(A_DATA, d);
      e = rx_q.pop_front();
      total_cnt++;
      if (d !== e) $display("FAIL full_pp_drain got=%02h exp=%02h", d, e); else pass_cnt++;
    end
    // on an empty FIFO only the push takes effect
    b = 8'($urandom);
    read_and_push(b, d);
    rx_q.push_back(b);
    cpu_read(A_RXCNT, d);
    total_cnt++;
    if (d !== 8'd1) $display("FAIL empty_pp_cnt got=%02h exp=01", d); else pass_cnt++;
    cpu_read(A_DATA, d);
    e = rx_q.pop_front();
    total_cnt++;
    if (d !== e) $display("FAIL empty_pp_data got=%02h exp=%02h", d, e); else pass_cnt++;
  endtask

  task automatic test_tx_drain();
    int wr_cyc;
    tx_busy = 1'b0;
    obs_q.delete(); obs_cyc.delete(); exp_q.delete();
    cpu_write(A_DATA, 8'h11); exp_q.push_back(8'h11);
    wr_cyc = cyc;
    cpu_write(A_DATA, 8'h22); exp_q.push_back(8'h22);
    cpu_write(A_DATA, 8'h33); exp_q.push_back(8'h33);
    wait_obs(3, 40);
    total_cnt++;
    if (obs_q.size() != 3) $display("FAIL tx_pulse_count got=%0d exp=3", obs_q.size());
    else begin
      pass_cnt++;
      total_cnt++;
      if (obs_cyc[0] != wr_cyc + 1) $display("FAIL tx_latency got=%0d exp=%0d", obs_cyc[0] - wr_cyc, 1);
      else pass_cnt++;
      for (int i = 0; i < 3; i++) begin
        total_cnt++;
        if (obs_q[i] !== exp_q[i]) $display("FAIL tx_data%0d got=%02h exp=%02h", i, obs_q[i], exp_q[i]);
        else pass_cnt++;
        if (i > 0) begin
          total_cnt++;
          if (obs_cyc[i] - obs_cyc[i-1] != 3) $display("FAIL tx_spacing%0d got=%0d exp=3", i, obs_cyc[i] - obs_cyc[i-1]);
          else pass_cnt++;
        end
      end
    end
    repeat (4) @(negedge clock);
  endtask

  task automatic test_tx_busy();
    logic [7:0] d;
    tx_busy = 1'b1;
    obs_q.delete(); obs_cyc.delete(); exp_q.delete();
    for (int i = 0; i < 6; i++) begin
      d = 8'($urandom);
      cpu_write(A_DATA, d);
      if (exp_q.size() < TX_DEPTH) exp_q.push_back(d);
    end
    repeat (5) @(negedge clock);
    total_cnt++;
    if (obs_q.size() != 0) $display("FAIL busy_hold got=%0d pulses exp=0", obs_q.size()); else pass_cnt++;
    cpu_read(A_TXCNT, d);
    total_cnt++;
    if (d !== 8'(exp_q.size())) $display("FAIL busy_txcnt got=%02h exp=%02h", d, 8'(exp_q.size())); else pass_cnt++;
    cpu_read(A_STAT, d);
    total_cnt++;
    if (d !== exp_stat(exp_q.size())) $display("FAIL busy_stat got=%02h exp=%02h", d, exp_stat(exp_q.size())); else pass_cnt++;
    tx_busy = 1'b0;
    wait_obs(4, 60);
    total_cnt++;
    if (obs_q.size() != 4) $display("FAIL busy_release got=%0d pulses exp=4", obs_q.size());
    else begin
      pass_cnt++;
      for (int i = 0; i < 4; i++) begin
        total_cnt++;
        if (obs_q[i] !== exp_q[i]) $display("FAIL busy_data%0d got=%02h exp=%02h", i, obs_q[i], exp_q[i]);
        else pass_cnt++;
      end
    end
    repeat (4) @(negedge clock);
    cpu_read(A_TXCNT, d);
    total_cnt++;
    if (d !== 8'h00) $display("FAIL busy_txcnt_end got=%02h exp=00", d); else pass_cnt++;
  endtask

  task automatic test_irq();
    logic [7:0] d, e;
    cpu_write(A_CTRL, 8'h01);
    repeat (2) @(negedge clock);
    total_cnt++;
    if (irq !== 1'b0) $display("FAIL irq_rx_idle got=%b exp=0", irq); else pass_cnt++;
    e = 8'($urandom);
    rx_pulse(e); model_rx_push(e);
    total_cnt++;
    if (irq !== 1'b0) $display("FAIL irq_rx_early got=%b exp=0", irq); else pass_cnt++;
    @(negedge clock);
    total_cnt++;
    if (irq !== 1'b1) $display("FAIL irq_rx_set got=%b exp=1", irq); else pass_cnt++;
    cpu_read(A_CTRL, d);
    total_cnt++;
    if (d !== 8'h01) $display("FAIL irq_ctrl_rb got=%02h exp=01", d); else pass_cnt++;
    cpu_read(A_DATA, d);
    void'(rx_q.pop_front());
    @(negedge clock);
    total_cnt++;
    if (irq !== 1'b0) $display("FAIL irq_rx_clr got=%b exp=0", irq); else pass_cnt++;
    cpu_write(A_CTRL, 8'h02);
    @(negedge clock);
    total_cnt++;
    if (irq !== 1'b1) $display("FAIL irq_tx_empty got=%b exp=1", irq); else pass_cnt++;
    cpu_write(A_CTRL, 8'h04);
    repeat (2) @(negedge clock);
    total_cnt++;
    if (irq !== 1'b0) $display("FAIL irq_ov_idle got=%b exp=0", irq); else pass_cnt++;
    for (int i = 0; i < 5; i++) begin
      e = 8'($urandom);
      rx_pulse(e); model_rx_push(e);
    end
    repeat (2) @(negedge clock);
    total_cnt++;
    if (irq !== 1'b1) $display("FAIL irq_ov_set got=%b exp=1", irq); else pass_cnt++;
    cpu_read(A_STAT, d);
    rx_ovr = 1'b0;
    repeat (2) @(negedge clock);
    total_cnt++;
    if (irq !== 1'b0) $display("FAIL irq_ov_clr got=%b exp=0", irq); else pass_cnt++;
    while (rx_q.size() != 0) begin
      cpu_read(A_DATA, d);
      void'(rx_q.pop_front());
    end
    cpu_write(A_CTRL, 8'h00);
  endtask

  task automatic test_flush();
    logic [7:0] d;
    tx_busy = 1'b1;
    obs_q.delete(); obs_cyc.delete(); exp_q.delete();
    cpu_write(A_CTRL, 8'h07);
    for (int i = 0; i < 5; i++) begin
      d = 8'($urandom);
      rx_pulse(d); model_rx_push(d);
    end
    cpu_write(A_DATA, 8'h5A); exp_q.push_back(8'h5A);
    cpu_write(A_DATA, 8'hC3); exp_q.push_back(8'hC3);
    @(negedge clock);
    cpu_io = 1'b1; cpu_wr = 1'b1; cpu_addr = A_CTRL; cpu_dout = 8'hC0;
    rx_valid = 1'b1; rx_data = 8'h77;
    @(negedge clock);
    cpu_io = 1'b0; cpu_wr = 1'b0; rx_valid = 1'b0;
    rx_q.delete(); rx_ovr = 1'b0; exp_q.delete();
    cpu_read(A_RXCNT, d);
    total_cnt++;
    if (d !== 8'h00) $display("FAIL flush_rxcnt got=%02h exp=00", d); else pass_cnt++;
    cpu_read(A_TXCNT, d);
    total_cnt++;
    if (d !== 8'h00) $display("FAIL flush_txcnt got=%02h exp=00", d); else pass_cnt++;
    cpu_read(A_STAT, d);
    total_cnt++;
    if (d !== exp_stat(0)) $display("FAIL flush_stat got=%02h exp=%02h", d, exp_stat(0)); else pass_cnt++;
    cpu_read(A_CTRL, d);
    total_cnt++;
    if (d !== 8'h00) $display("FAIL flush_ctrl got=%02h exp=00", d); else pass_cnt++;
    tx_busy = 1'b0;
    repeat (10) @(negedge clock);
    total_cnt++;
    if (obs_q.size() != 0) $display("FAIL flush_tx_quiet got=%0d pulses exp=0", obs_q.size()); else pass_cnt++;
  endtask

  task automatic test_random();
    logic [7:0] d, e, b;
    int op;
    for (int it = 0; it < 200; it++) begin
      op = $urandom_range(0, 5);
      case (op)
        0, 1: begin
          b = 8'($urandom);
          rx_pulse(b); model_rx_push(b);
        end
        2: begin
          cpu_read(A_DATA, d);
          if (rx_q.size() != 0) begin
            e = rx_q.pop_front();
            total_cnt++;
            if (d !== e) $display("FAIL rnd_data it=%0d got=%02h exp=%02h", it, d, e); else pass_cnt++;
          end
        end
        3: begin
          cpu_read(A_STAT, d);
          total_cnt++;
          if (d !== exp_stat(0)) $display("FAIL rnd_stat it=%0d got=%02h exp=%02h", it, d, exp_stat(0)); else pass_cnt++;
          rx_ovr = 1'b0;
        end
        4: begin
          cpu_read(A_RXCNT, d);
          total_cnt++;
          if (d !== 8'(rx_q.size())) $display("FAIL rnd_cnt it=%0d got=%02h exp=%02h", it, d, 8'(rx_q.size())); else pass_cnt++;
        end
        default: begin
          b = 8'($urandom);
          read_and_push(b, d);
          if (rx_q.size() != 0) begin
            e = rx_q.pop_front();
            total_cnt++;
            if (d !== e) $display("FAIL rnd_pp it=%0d got=%02h exp=%02h", it, d, e); else pass_cnt++;
          end
          rx_q.push_back(b);
        end
      endcase
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] d;
    bit seen;
    seen = 1'b0;
    rx_pulse(8'h12); model_rx_push(8'h12);
    tx_busy = 1'b0;
    cpu_write(A_DATA, 8'hAA);
    for (int i = 0; i < 10 && !seen; i++) begin
      if (tx_valid === 1'b1) seen = 1'b1;
      else @(negedge clock);
    end
    total_cnt++;
    if (!seen) $display("FAIL mid_tx_seen got=0 exp=1"); else pass_cnt++;
    #2 reset2 = 1'b1;
    #1;
    total_cnt++;
    if ({tx_valid, irq, tx_data} !== 10'd0) $display("FAIL mid_reset_out tx_valid=%b irq=%b tx_data=%02h exp=0", tx_valid, irq, tx_data);
    else pass_cnt++;
    @(negedge clock);
    reset2 = 1'b0;
    rx_q.delete(); rx_ovr = 1'b0; exp_q.delete();
    cpu_read(A_RXCNT, d);
    total_cnt++;
    if (d !== 8'h00) $display("FAIL mid_rxcnt got=%02h exp=00", d); else pass_cnt++;
    cpu_read(A_STAT, d);
    total_cnt++;
    if (d !== exp_stat(0)) $display("FAIL mid_stat got=%02h exp=%02h", d, exp_stat(0)); else pass_cnt++;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached after %0d cycles", cyc);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_rx_order();
    test_overrun();
    test_same_cycle();
    test_tx_drain();
    test_tx_busy();
    test_irq();
    test_flush();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
